// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the frame header bytes the sources put at the start of each frame.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  localparam logic [7:0] HDR_SYNC = 8'h05;
  localparam logic [7:0] HDR_LEN  = 8'h64;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: the winner is the first requester found
// scanning upward from ptr+1 and wrapping, so ptr itself has lowest priority.
module rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         valid
);

  int best_d;
  int d;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    best_d = N;
    d      = 0;
    for (int i = 0; i < N; i++) begin
      // distance from the slot just after ptr, modulo N
      d = (i - int'(ptr) - 1 + 2 * N) % N;
      if (req[i] && (d < best_d)) begin
        best_d = d;
        winner = W'(i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared UART transmitter; a source keeps the grant
// for a whole frame. Optional idle-grant timeout enabled by ARB_TIMEOUT_EN.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no owner; pick next requester after rr_ptr
//   ST_GRANT   | owner may strobe a byte or drop its request
//   ST_BUSY    | byte handed to the UART, waiting for uart_tx_done
//   ST_RELEASE | grant dropped, one forced idle cycle before arbitrating
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int IDW         = 1,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   src_req,
  input  logic [N_REQ-1:0]   src_tx_en,
  input  logic [8*N_REQ-1:0] src_tx_data,
  output logic [N_REQ-1:0]   src_grant,
  output logic [N_REQ-1:0]   src_tx_done,
  output logic               uart_tx_en,
  output logic [7:0]         uart_tx_data,
  input  logic               uart_tx_done,
  output logic [IDW-1:0]     grant_id,
  output logic [15:0]        frame_bytes,
  output logic               err_collision,
  output logic               timeout_flag
);

  if ((IDW < 1) || (TIMEOUT_CYC < 2) || ((N_REQ > 1) && ((1 << IDW) < N_REQ)))
  begin : g_bad_params
    $error("uart_tx_arbiter: inconsistent N_REQ/IDW/TIMEOUT_CYC");
  end

  arb_state_t       state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   pick_winner;
  logic             pick_valid;
  logic [N_REQ-1:0] pick_oh;
  logic [N_REQ-1:0] gid_oh;
  logic [7:0]       sel_byte;
  logic             collision;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_cnt;
`endif

  rr_picker #(
    .N (N_REQ),
    .W (IDW)
  ) u_rr_picker (
    .req    (src_req),
    .ptr    (rr_ptr),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  always_comb begin
    pick_oh              = '0;
    pick_oh[pick_winner] = 1'b1;
    gid_oh               = '0;
    gid_oh[grant_id]     = 1'b1;
  end

  assign sel_byte = src_tx_data[{grant_id, 3'b000} +: 8];

  // a strobe from anyone but the owner, or from the owner while a byte is in flight
  assign collision = (|(src_tx_en & ~gid_oh)) ||
                     ((state == ST_BUSY) && src_tx_en[grant_id]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      src_grant     <= '0;
      src_tx_done   <= '0;
      uart_tx_en    <= 1'b0;
      uart_tx_data  <= '0;
      frame_bytes   <= '0;
      err_collision <= 1'b0;
      timeout_flag  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt       <= '0;
`endif
    end else begin
      uart_tx_en   <= 1'b0;
      src_tx_done  <= '0;
      timeout_flag <= 1'b0;
      if (collision) begin
        err_collision <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_id    <= pick_winner;
            src_grant   <= pick_oh;
            frame_bytes <= '0;
            state       <= ST_GRANT;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end
        end

        ST_GRANT: begin
          if (src_tx_en[grant_id]) begin
            uart_tx_en   <= 1'b1;
            uart_tx_data <= sel_byte;
            if (frame_bytes != 16'hFFFF) begin
              frame_bytes <= frame_bytes + 16'd1;
            end
            state <= ST_BUSY;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end else if (!src_req[grant_id]) begin
            src_grant <= '0;
            rr_ptr    <= grant_id;
            state     <= ST_RELEASE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            timeout_flag <= 1'b1;
            src_grant    <= '0;
            rr_ptr       <= grant_id;
            state        <= ST_RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        ST_BUSY: begin
          if (uart_tx_done) begin
            src_tx_done <= gid_oh;
            state       <= ST_GRANT;
          end
        end

        ST_RELEASE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: stimulus pushes expected bytes, done
// pulses and grants into queues that a negedge monitor pops and compares.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N_REQ    = 2;
  localparam int IDW      = 1;
  localparam int TMO      = 16;
  localparam int DONE_DLY = 10;

  logic               clk;
  logic               rst_n;
  logic [N_REQ-1:0]   src_req;
  logic [N_REQ-1:0]   src_tx_en;
  logic [8*N_REQ-1:0] src_tx_data;
  logic [N_REQ-1:0]   src_grant;
  logic [N_REQ-1:0]   src_tx_done;
  logic               uart_tx_en;
  logic [7:0]         uart_tx_data;
  logic               uart_tx_done;
  logic [IDW-1:0]     grant_id;
  logic [15:0]        frame_bytes;
  logic               err_collision;
  logic               timeout_flag;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } tx_exp_t;

  tx_exp_t          exp_tx[$];
  logic [N_REQ-1:0] exp_done[$];
  logic [N_REQ-1:0] exp_grant[$];
  tx_exp_t          e;
  logic [N_REQ-1:0] prev_grant;
  int               cyc;
  int               checks;
  int               failures;

  uart_tx_arbiter #(
    .N_REQ       (N_REQ),
    .IDW         (IDW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_req       (src_req),
    .src_tx_en     (src_tx_en),
    .src_tx_data   (src_tx_data),
    .src_grant     (src_grant),
    .src_tx_done   (src_tx_done),
    .uart_tx_en    (uart_tx_en),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_done  (uart_tx_done),
    .grant_id      (grant_id),
    .frame_bytes   (frame_bytes),
    .err_collision (err_collision),
    .timeout_flag  (timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents an event
  initial prev_grant = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (uart_tx_en) begin
        chk("tx_expected", 32'(exp_tx.size() != 0), 1);
        if (exp_tx.size() != 0) begin
          e = exp_tx.pop_front();
          chk("tx_data", 32'(uart_tx_data), 32'(e.data));
          chk("tx_latency_cycle", cyc, e.cyc);
        end
      end
      if (src_tx_done != '0) begin
        chk("done_expected", 32'(exp_done.size() != 0), 1);
        if (exp_done.size() != 0) chk("done_onehot", 32'(src_tx_done), 32'(exp_done.pop_front()));
      end
      if ((src_grant != '0) && (src_grant != prev_grant)) begin
        chk("grant_expected", 32'(exp_grant.size() != 0), 1);
        if (exp_grant.size() != 0) chk("grant_order", 32'(src_grant), 32'(exp_grant.pop_front()));
      end
    end
    prev_grant <= src_grant;
  end

  // UART model: completes each byte about DONE_DLY cycles after its strobe
  initial begin
    uart_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx_en) begin
        repeat (DONE_DLY - 1) @(posedge clk);
        #1 uart_tx_done = 1'b1;
        @(posedge clk);
        #1 uart_tx_done = 1'b0;
      end
    end
  end

  task automatic wait_grant(input int s);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (src_grant[s]) begin
        seen = 1'b1;
        break;
      end
    end
    chk($sformatf("grant_seen_src%0d", s), 32'(seen), 1);
  endtask

  task automatic wait_done(input int s);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (src_tx_done[s]) begin
        seen = 1'b1;
        break;
      end
    end
    chk($sformatf("done_seen_src%0d", s), 32'(seen), 1);
  endtask

  task automatic strobe(input int s, input logic [7:0] b, input bit expect_done);
    logic [N_REQ-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    src_tx_data[8*s +: 8] = b;
    src_tx_en[s] = 1'b1;
    exp_tx.push_back('{data: b, cyc: cyc + 1});
    if (expect_done) exp_done.push_back(oh);
    @(posedge clk);
    #1 src_tx_en[s] = 1'b0;
  endtask

  task automatic send_byte(input int s, input logic [7:0] b);
    strobe(s, b, 1'b1);
    wait_done(s);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 32'(src_grant), 0);
    chk({tag, "_done"}, 32'(src_tx_done), 0);
    chk({tag, "_tx_en"}, 32'(uart_tx_en), 0);
    chk({tag, "_tx_data"}, 32'(uart_tx_data), 0);
    chk({tag, "_grant_id"}, 32'(grant_id), 0);
    chk({tag, "_frame_bytes"}, 32'(frame_bytes), 0);
    chk({tag, "_err"}, 32'(err_collision), 0);
    chk({tag, "_timeout"}, 32'(timeout_flag), 0);
  endtask

  initial begin
    int g;
    int t;
    bit seen;
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    src_req     = '0;
    src_tx_en   = '0;
    src_tx_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: single source, three-byte frame
    exp_grant.push_back(2'b01);
    src_req = 2'b01;
    wait_grant(0);
    @(posedge clk);
    #1;
    send_byte(0, HDR_SYNC);
    send_byte(0, HDR_LEN);
    send_byte(0, 8'hAA);
    chk("t1_frame_bytes", 32'(frame_bytes), 3);
    src_req = 2'b00;
    @(negedge clk);
    chk("t1_grant_held", 32'(src_grant), 32'b01);
    @(negedge clk);
    chk("t1_grant_drop", 32'(src_grant), 0);

    // 2: contention from reset, rr_ptr=0 so source 1 wins first
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_grant.push_back(2'b10);
    exp_grant.push_back(2'b01);
    src_req = 2'b11;
    wait_grant(1);
    chk("t2_first_gid", 32'(grant_id), 1);
    @(posedge clk);
    #1;
    send_byte(1, 8'h05);
    send_byte(1, 8'h64);
    chk("t2_frame_bytes", 32'(frame_bytes), 2);
    src_req[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t2_idle_gap", 32'(src_grant), 0);
    wait_grant(0);
    chk("t2_second_gid", 32'(grant_id), 0);
    @(posedge clk);
    #1;
    send_byte(0, 8'h11);

    // 3: collision from the non-granted source
    chk("t3_err_clear", 32'(err_collision), 0);
    src_tx_data[15:8] = 8'hEE;
    src_tx_en[1] = 1'b1;
    @(posedge clk);
    #1 src_tx_en[1] = 1'b0;
    @(negedge clk);
    chk("t3_err_set", 32'(err_collision), 1);
    chk("t3_no_tx", 32'(uart_tx_en), 0);
    chk("t3_data_kept", 32'(uart_tx_data), 32'h11);
    @(posedge clk);
    #1;
    send_byte(0, 8'h22);
    chk("t3_err_sticky", 32'(err_collision), 1);
    chk("t3_data_hold", 32'(uart_tx_data), 32'h22);

    // 4: request dropped two cycles after the strobe, during BUSY
    strobe(0, 8'h33, 1'b1);
    @(posedge clk);
    #1 src_req[0] = 1'b0;
    wait_done(0);
    chk("t4_grant_until_done", 32'(src_grant), 32'b01);
    @(negedge clk);
    chk("t4_release", 32'(src_grant), 0);
    @(posedge clk);
    #1;

    // 5: reset while a byte is in flight; no done pulse may follow
    exp_grant.push_back(2'b01);
    src_req = 2'b01;
    wait_grant(0);
    @(posedge clk);
    #1;
    strobe(0, 8'h44, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b0;
    src_req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("t5_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;

    // 6: grant held without strobing
    exp_grant.push_back(2'b01);
    src_req = 2'b01;
    wait_grant(0);
    g    = cyc;
    t    = 0;
    seen = 1'b0;
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (timeout_flag) begin
        seen = 1'b1;
        t    = cyc;
        break;
      end
    end
    src_req = 2'b00;
    chk("t6_timeout_seen", 32'(seen), 1);
    chk("t6_timeout_delay", t - g, TMO);
    chk("t6_grant_cleared", 32'(src_grant), 0);
`else
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (timeout_flag) seen = 1'b1;
    end
    chk("t6_no_timeout", 32'(seen), 0);
    chk("t6_grant_held", 32'(src_grant), 32'b01);
    src_req = 2'b00;
`endif
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("end_grant_idle", 32'(src_grant), 0);
    chk("end_tx_queue", exp_tx.size(), 0);
    chk("end_done_queue", exp_done.size(), 0);
    chk("end_grant_queue", exp_grant.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

endmodule
